// File: rtl/dependency_tracker.sv
// dependency_tracker: per-register producer table tracking in-flight ROB tags and forwarded writeback results.
// Define DEPENDENCY_BYPASS_EN to forward same-cycle writeback broadcasts to lookups.
module dependency_tracker #(
    parameter int ID_SIZE          = 3,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int REGISTER_SIZE    = 32,
    parameter int N_READ           = 2,
    parameter int N_WB             = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       alloc_valid,
    input  logic [REG_ADDRESS_SIZE-1:0]                alloc_addr,
    input  logic [ID_SIZE-1:0]                         alloc_id,
    input  logic [N_WB-1:0]                            wb_valid,
    input  logic [N_WB-1:0][ID_SIZE-1:0]               wb_id,
    input  logic [N_WB-1:0][REGISTER_SIZE-1:0]         wb_value,
    input  logic                                       commit_valid,
    input  logic [REG_ADDRESS_SIZE-1:0]                commit_addr,
    input  logic [ID_SIZE-1:0]                         commit_id,
    input  logic                                       flush,
    input  logic [N_READ-1:0][REG_ADDRESS_SIZE-1:0]    rd_addr,
    output logic [N_READ-1:0]                          dependency,
    output logic [N_READ-1:0]                          resolved,
    output logic [N_READ-1:0][REGISTER_SIZE-1:0]       value,
    output logic [N_READ-1:0][ID_SIZE-1:0]             rd_id,
    output logic [REG_ADDRESS_SIZE:0]                  pending_count
);
    localparam int NE = 1 << REG_ADDRESS_SIZE;

    logic [NE-1:0]              pend_q, pend_d, rdy_q, rdy_d;
    logic [ID_SIZE-1:0]         tag_q [NE];
    logic [ID_SIZE-1:0]         tag_d [NE];
    logic [REGISTER_SIZE-1:0]   data_q [NE];
    logic [REGISTER_SIZE-1:0]   data_d [NE];
    logic [REGISTER_SIZE:0]     wbm [NE];
    logic [REG_ADDRESS_SIZE:0]  cnt_q, cnt_d;

    // {hit, value} of the lowest-index valid writeback port carrying tag t
    function automatic logic [REGISTER_SIZE:0] wb_match(input logic [ID_SIZE-1:0] t);
        wb_match = '0;
        for (int p = N_WB - 1; p >= 0; p--)
            if (wb_valid[p] && wb_id[p] == t) wb_match = {1'b1, wb_value[p]};
    endfunction

    always_comb begin
        for (int r = 0; r < NE; r++) wbm[r] = wb_match(tag_q[r]);
    end

    always_comb begin
        pend_d = pend_q;
        rdy_d  = rdy_q;
        tag_d  = tag_q;
        data_d = data_q;
        cnt_d  = '0;
        for (int r = 1; r < NE; r++) begin
            if (flush) begin
                pend_d[r] = 1'b0;
                rdy_d[r]  = 1'b0;
            end else if (alloc_valid && alloc_addr == REG_ADDRESS_SIZE'(r)) begin
                pend_d[r] = 1'b1;
                rdy_d[r]  = 1'b0;
                tag_d[r]  = alloc_id;
                data_d[r] = '0;
            end else if (commit_valid && commit_addr == REG_ADDRESS_SIZE'(r) && pend_q[r] && tag_q[r] == commit_id) begin
                pend_d[r] = 1'b0;
                rdy_d[r]  = 1'b0;
            end else if (pend_q[r] && !rdy_q[r] && wbm[r][REGISTER_SIZE]) begin
                rdy_d[r]  = 1'b1;
                data_d[r] = wbm[r][REGISTER_SIZE-1:0];
            end
            cnt_d = cnt_d + (REG_ADDRESS_SIZE + 1)'(pend_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            rdy_q  <= '0;
            tag_q  <= '{default: '0};
            data_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            rdy_q  <= rdy_d;
            tag_q  <= tag_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_count = cnt_q;

`ifdef DEPENDENCY_BYPASS_EN
    logic [REGISTER_SIZE:0] byp [N_READ];
    always_comb begin
        for (int i = 0; i < N_READ; i++) byp[i] = wbm[rd_addr[i]];
    end
`endif

    // Entry 0 is never written, so pend_q[0] keeps r0 lookups at zero
    always_comb begin
        for (int i = 0; i < N_READ; i++) begin
            dependency[i] = pend_q[rd_addr[i]];
            resolved[i]   = pend_q[rd_addr[i]] && rdy_q[rd_addr[i]];
            rd_id[i]      = dependency[i] ? tag_q[rd_addr[i]] : '0;
            value[i]      = resolved[i] ? data_q[rd_addr[i]] : '0;
`ifdef DEPENDENCY_BYPASS_EN
            if (dependency[i] && !resolved[i] && byp[i][REGISTER_SIZE]) begin
                resolved[i] = 1'b1;
                value[i]    = byp[i][REGISTER_SIZE-1:0];
            end
`endif
        end
    end
endmodule
